// File: rtl/ic_tag_wr_ctl.sv
`default_nettype none
// ============================================================================
// Module   : ic_tag_wr_ctl
// Brief    : I-cache tag RAM write-port controller. It runs the invalidate
//            sweep after reset and on flush, and arbitrates refill installs
//            and single-line invalidates onto the RAM's one write port.
//            Optional stats counters: define IC_TAG_WR_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ic_tag_wr_ctl #(
    parameter int LINE_W = 8,
    parameter int TAG_W  = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_req_i,
    output logic              busy_o,
    output logic              init_done_o,
    input  logic              inst_valid_i,
    output logic              inst_ready_o,
    input  logic [LINE_W-1:0] inst_line_i,
    input  logic [TAG_W-1:0]  inst_tag_i,
    input  logic              inv_valid_i,
    output logic              inv_ready_o,
    input  logic [LINE_W-1:0] inv_line_i,
`ifdef IC_TAG_WR_STATS_EN
    output logic [15:0]       stat_inst_cnt_o,
    output logic [15:0]       stat_inv_cnt_o,
`endif
    output logic              wr_en_o,
    output logic [LINE_W-1:0] wr_line_o,
    output logic [TAG_W:0]    wr_data_o
);

    typedef enum logic [0:0] {
        ST_SWEEP = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [LINE_W-1:0]   cnt_q, cnt_d;
    logic                wr_en_q, wr_en_d;
    logic [LINE_W-1:0]   wr_line_q, wr_line_d;
    logic [TAG_W:0]      wr_data_q, wr_data_d;
    logic                init_done_q, init_done_d;
    logic                inst_acc_w;
    logic                inv_acc_w;

    // Flush outranks both requesters; install outranks invalidate.
    assign inst_ready_o = (state_q == ST_IDLE) && !flush_req_i;
    assign inv_ready_o  = (state_q == ST_IDLE) && !flush_req_i && !inst_valid_i;
    assign inst_acc_w   = inst_valid_i && inst_ready_o;
    assign inv_acc_w    = inv_valid_i && inv_ready_o;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_en_d     = 1'b0;
        wr_line_d   = wr_line_q;
        wr_data_d   = wr_data_q;
        init_done_d = init_done_q;
        case (state_q)
            ST_SWEEP: begin
                // Flush requests are ignored here; the running sweep already covers every line.
                wr_en_d   = 1'b1;
                wr_line_d = cnt_q;
                wr_data_d = '0;
                cnt_d     = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end
            end
            default: begin
                if (flush_req_i) begin
                    state_d = ST_SWEEP;
                    cnt_d   = '0;
                end else if (inst_acc_w) begin
                    wr_en_d   = 1'b1;
                    wr_line_d = inst_line_i;
                    wr_data_d = {1'b1, inst_tag_i};
                end else if (inv_acc_w) begin
                    wr_en_d   = 1'b1;
                    wr_line_d = inv_line_i;
                    wr_data_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_SWEEP;
            cnt_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_line_q   <= '0;
            wr_data_q   <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_en_q     <= wr_en_d;
            wr_line_q   <= wr_line_d;
            wr_data_q   <= wr_data_d;
            init_done_q <= init_done_d;
        end
    end

    assign busy_o      = (state_q == ST_SWEEP);
    assign init_done_o = init_done_q;
    assign wr_en_o     = wr_en_q;
    assign wr_line_o   = wr_line_q;
    assign wr_data_o   = wr_data_q;

`ifdef IC_TAG_WR_STATS_EN
    logic [15:0] stat_inst_q;
    logic [15:0] stat_inv_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_inst_q <= '0;
            stat_inv_q  <= '0;
        end else begin
            if (inst_acc_w && !(&stat_inst_q)) begin
                stat_inst_q <= stat_inst_q + 16'd1;
            end
            if (inv_acc_w && !(&stat_inv_q)) begin
                stat_inv_q <= stat_inv_q + 16'd1;
            end
        end
    end

    assign stat_inst_cnt_o = stat_inst_q;
    assign stat_inv_cnt_o  = stat_inv_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ic_tag_wr_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ic_tag_wr_ctl
// Brief    : Randomized bench for ic_tag_wr_ctl against a sweep-position
//            reference model; stats checks when IC_TAG_WR_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ic_tag_wr_ctl;
    localparam int LINE_W = 8;
    localparam int TAG_W  = 15;
    localparam int LINES  = 1 << LINE_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush_req;
    logic              busy;
    logic              init_done;
    logic              inst_valid;
    logic              inst_ready;
    logic [LINE_W-1:0] inst_line;
    logic [TAG_W-1:0]  inst_tag;
    logic              inv_valid;
    logic              inv_ready;
    logic [LINE_W-1:0] inv_line;
    logic              wr_en;
    logic [LINE_W-1:0] wr_line;
    logic [TAG_W:0]    wr_data;
`ifdef IC_TAG_WR_STATS_EN
    logic [15:0]       stat_inst_cnt;
    logic [15:0]       stat_inv_cnt;
`endif

    ic_tag_wr_ctl #(.LINE_W(LINE_W), .TAG_W(TAG_W)) u_dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .flush_req_i    (flush_req),
        .busy_o         (busy),
        .init_done_o    (init_done),
        .inst_valid_i   (inst_valid),
        .inst_ready_o   (inst_ready),
        .inst_line_i    (inst_line),
        .inst_tag_i     (inst_tag),
        .inv_valid_i    (inv_valid),
        .inv_ready_o    (inv_ready),
        .inv_line_i     (inv_line),
`ifdef IC_TAG_WR_STATS_EN
        .stat_inst_cnt_o(stat_inst_cnt),
        .stat_inv_cnt_o (stat_inv_cnt),
`endif
        .wr_en_o        (wr_en),
        .wr_line_o      (wr_line),
        .wr_data_o      (wr_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: sweep_pos is the next line the sweep will write, -1 when idle.
    int          sweep_pos;
    bit          m_init;
    bit          m_wr_en;
    int unsigned m_line;
    int unsigned m_data;
    int unsigned m_inst_cnt;
    int unsigned m_inv_cnt;
    bit          inst_acc;
    bit          inv_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        sweep_pos  = 0;
        m_init     = 1'b0;
        m_wr_en    = 1'b0;
        m_line     = 0;
        m_data     = 0;
        m_inst_cnt = 0;
        m_inv_cnt  = 0;
    endtask

    task automatic check_outputs();
        chk("wr_en", 32'(wr_en), 32'(m_wr_en));
        chk("wr_line", 32'(wr_line), m_line);
        chk("wr_data", 32'(wr_data), m_data);
        chk("busy", 32'(busy), 32'(sweep_pos >= 0));
        chk("init_done", 32'(init_done), 32'(m_init));
`ifdef IC_TAG_WR_STATS_EN
        chk("stat_inst", 32'(stat_inst_cnt), m_inst_cnt);
        chk("stat_inv", 32'(stat_inv_cnt), m_inv_cnt);
`endif
    endtask

    // One clock: check readies mid-cycle, advance the model, check the registered outputs.
    task automatic step();
        bit idle, e_inst_rdy, e_inv_rdy;
        @(negedge clk);
        idle       = (sweep_pos < 0);
        e_inst_rdy = idle && !flush_req;
        e_inv_rdy  = idle && !flush_req && !inst_valid;
        chk("inst_ready", 32'(inst_ready), 32'(e_inst_rdy));
        chk("inv_ready", 32'(inv_ready), 32'(e_inv_rdy));
        inst_acc = inst_valid && e_inst_rdy;
        inv_acc  = inv_valid && e_inv_rdy;
        if (!idle) begin
            m_wr_en = 1'b1;
            m_line  = sweep_pos;
            m_data  = 0;
            sweep_pos++;
            if (sweep_pos == LINES) begin
                sweep_pos = -1;
                m_init    = 1'b1;
            end
        end else if (flush_req) begin
            m_wr_en   = 1'b0;
            sweep_pos = 0;
        end else if (inst_acc) begin
            m_wr_en = 1'b1;
            m_line  = inst_line;
            m_data  = (1 << TAG_W) + inst_tag;
        end else if (inv_acc) begin
            m_wr_en = 1'b1;
            m_line  = inv_line;
            m_data  = 0;
        end else begin
            m_wr_en = 1'b0;
        end
        if (inst_acc && m_inst_cnt < 65535) m_inst_cnt++;
        if (inv_acc && m_inv_cnt < 65535) m_inv_cnt++;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        rst        = 1'b1;
        flush_req  = 1'b0;
        inst_valid = 1'b1;
        inst_line  = 8'h12;
        inst_tag   = 15'h1ABC;
        inv_valid  = 1'b0;
        inv_line   = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b0;

        // Power-up sweep with an install held throughout; it must land right after line 0xFF.
        for (int i = 0; i < LINES; i++) step();
        chk("sweep_last_line", 32'(wr_line), 32'hFF);
        step();
        chk("first_inst_line", 32'(wr_line), 32'h12);
        chk("first_inst_data", 32'(wr_data), 32'h9ABC);
        inst_valid = 1'b0;
        step();

        // Same-line install and invalidate in one cycle: install first, invalidate next.
        inst_valid = 1'b1; inst_line = 8'h05; inst_tag = 15'h0001;
        inv_valid  = 1'b1; inv_line  = 8'h05;
        step();
        chk("coll_inst_data", 32'(wr_data), 32'h8001);
        inst_valid = 1'b0;
        step();
        chk("coll_inv_en", 32'(wr_en), 32'h1);
        chk("coll_inv_data", 32'(wr_data), 32'h0000);
        inv_valid = 1'b0;
        step();

        // Flush pulse while an invalidate waits; the invalidate goes after the full sweep.
        inv_valid = 1'b1; inv_line = 8'h33; flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        for (int i = 0; i < LINES + 1; i++) step();
        chk("post_flush_inv_line", 32'(wr_line), 32'h33);
        inv_valid = 1'b0;
        step();

        // Randomized traffic with hold-until-accepted requesters and occasional flushes.
        for (int i = 0; i < 3000; i++) begin
            if (inst_acc || !inst_valid) begin
                inst_valid = ($urandom_range(0, 2) != 0);
                inst_line  = LINE_W'($urandom_range(0, 7));
                inst_tag   = TAG_W'($urandom);
            end
            if (inv_acc || !inv_valid) begin
                inv_valid = ($urandom_range(0, 1) != 0);
                inv_line  = LINE_W'($urandom_range(0, 7));
            end
            if (flush_req && busy) flush_req = 1'b0;
            else if (!busy && $urandom_range(0, 299) == 0) flush_req = 1'b1;
            step();
        end
        inst_valid = 1'b0; inv_valid = 1'b0; flush_req = 1'b0;
        while (sweep_pos >= 0) step();

        // Asynchronous reset in the middle of a sweep.
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        while (sweep_pos != 8'h81) step();
        chk("mid_sweep_line", 32'(wr_line), 32'h80);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("restart_line", 32'(wr_line), 32'h03);
        while (sweep_pos >= 0) step();

`ifdef IC_TAG_WR_STATS_EN
        // Counters from this fresh reset: 3 installs and 2 invalidates, then saturation.
        for (int i = 0; i < 3; i++) begin
            inst_valid = 1'b1; inst_line = LINE_W'(i); inst_tag = TAG_W'(i);
            step();
        end
        inst_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            inv_valid = 1'b1; inv_line = LINE_W'(i);
            step();
        end
        inv_valid = 1'b0;
        step();
        chk("stat_inst_3", 32'(stat_inst_cnt), 32'd3);
        chk("stat_inv_2", 32'(stat_inv_cnt), 32'd2);
        inst_valid = 1'b1;
        for (int i = 0; i < 65534; i++) step();
        chk("stat_inst_sat", 32'(stat_inst_cnt), 32'hFFFF);
        inst_valid = 1'b0;
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
